// File: rtl/decode_e_stage.sv
// Y86-64 decode stage: register-ID decode, 15-entry register file written from W,
// valA/valB forwarding network and the E pipeline register with bubble insertion.
// Optional debug read port enabled by defining DBG_REGFILE_EN.
module decode_e_stage #(
  parameter int unsigned WIDTH  = 64,
  parameter logic [3:0]  RSP_ID = 4'h4,
  parameter logic [3:0]  RNONE  = 4'hF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       D_stat,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       D_ifun,
  input  logic [3:0]       D_rA,
  input  logic [3:0]       D_rB,
  input  logic [WIDTH-1:0] D_valC,
  input  logic [WIDTH-1:0] D_valP,
  input  logic             E_bubble,
  input  logic [3:0]       e_dstE,
  input  logic [WIDTH-1:0] e_valE,
  input  logic [3:0]       M_dstM,
  input  logic [3:0]       M_dstE,
  input  logic [WIDTH-1:0] m_valM,
  input  logic [WIDTH-1:0] M_valE,
  input  logic [3:0]       W_dstM,
  input  logic [3:0]       W_dstE,
  input  logic [WIDTH-1:0] W_valM,
  input  logic [WIDTH-1:0] W_valE,
  output logic [3:0]       d_srcA,
  output logic [3:0]       d_srcB,
  output logic [2:0]       E_stat,
  output logic [3:0]       E_icode,
  output logic [3:0]       E_ifun,
  output logic [WIDTH-1:0] E_valC,
  output logic [WIDTH-1:0] E_valA,
  output logic [WIDTH-1:0] E_valB,
  output logic [3:0]       E_dstE,
  output logic [3:0]       E_dstM,
  output logic [3:0]       E_srcA,
  output logic [3:0]       E_srcB
`ifdef DBG_REGFILE_EN
  ,
  input  logic [3:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data
`endif
);

  localparam logic [2:0] StatAok = 3'd1;
  localparam logic [3:0] INop    = 4'h1;

  logic [WIDTH-1:0] regs_q [15];
  logic [WIDTH-1:0] regs_d [15];

  logic [3:0]       d_dstE, d_dstM;
  logic [WIDTH-1:0] d_valA, d_valB;
  logic [WIDTH-1:0] rf_a, rf_b;

  logic [2:0]       ereg_stat_q, ereg_stat_d;
  logic [3:0]       ereg_icode_q, ereg_icode_d;
  logic [3:0]       ereg_ifun_q, ereg_ifun_d;
  logic [WIDTH-1:0] ereg_valc_q, ereg_valc_d;
  logic [WIDTH-1:0] ereg_vala_q, ereg_vala_d;
  logic [WIDTH-1:0] ereg_valb_q, ereg_valb_d;
  logic [3:0]       ereg_dste_q, ereg_dste_d;
  logic [3:0]       ereg_dstm_q, ereg_dstm_d;
  logic [3:0]       ereg_srca_q, ereg_srca_d;
  logic [3:0]       ereg_srcb_q, ereg_srcb_d;

  // RNONE is never a valid forwarding match.
  function automatic logic hit(input logic [3:0] src, input logic [3:0] dst);
    return (src != RNONE) && (src == dst);
  endfunction

  function automatic logic [WIDTH-1:0] rf_read(input logic [3:0] id);
    logic [WIDTH-1:0] val;
    val = '0;
    if (id != RNONE) val = regs_q[id];
    return val;
  endfunction

  // Source/destination register ID decode.
  always_comb begin
    d_srcA = RNONE;
    d_srcB = RNONE;
    d_dstE = RNONE;
    d_dstM = RNONE;
    case (D_icode)
      4'h2, 4'h4, 4'h6, 4'hA: d_srcA = D_rA;
      4'h9, 4'hB:             d_srcA = RSP_ID;
      default:                d_srcA = RNONE;
    endcase
    case (D_icode)
      4'h4, 4'h5, 4'h6:       d_srcB = D_rB;
      4'h8, 4'h9, 4'hA, 4'hB: d_srcB = RSP_ID;
      default:                d_srcB = RNONE;
    endcase
    case (D_icode)
      4'h2, 4'h3, 4'h6:       d_dstE = D_rB;
      4'h8, 4'h9, 4'hA, 4'hB: d_dstE = RSP_ID;
      default:                d_dstE = RNONE;
    endcase
    case (D_icode)
      4'h5, 4'hB: d_dstM = D_rA;
      default:    d_dstM = RNONE;
    endcase
  end

  // Forwarding network: youngest producer wins, register file last.
  always_comb begin
    rf_a = rf_read(d_srcA);
    rf_b = rf_read(d_srcB);
    if ((D_icode == 4'h7) || (D_icode == 4'h8)) d_valA = D_valP;
    else if (hit(d_srcA, e_dstE))               d_valA = e_valE;
    else if (hit(d_srcA, M_dstM))               d_valA = m_valM;
    else if (hit(d_srcA, M_dstE))               d_valA = M_valE;
    else if (hit(d_srcA, W_dstM))               d_valA = W_valM;
    else if (hit(d_srcA, W_dstE))               d_valA = W_valE;
    else                                        d_valA = rf_a;

    if (hit(d_srcB, e_dstE))      d_valB = e_valE;
    else if (hit(d_srcB, M_dstM)) d_valB = m_valM;
    else if (hit(d_srcB, M_dstE)) d_valB = M_valE;
    else if (hit(d_srcB, W_dstM)) d_valB = W_valM;
    else if (hit(d_srcB, W_dstE)) d_valB = W_valE;
    else                          d_valB = rf_b;
  end

  // Register-file write: dstM applied after dstE so valM wins on a collision.
  always_comb begin
    for (int i = 0; i < 15; i++) regs_d[i] = regs_q[i];
    if (W_dstE != RNONE) regs_d[W_dstE] = W_valE;
    if (W_dstM != RNONE) regs_d[W_dstM] = W_valM;
  end

  // Register-file state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 15; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < 15; i++) regs_q[i] <= regs_d[i];
    end
  end

  // E register next state: nop on bubble, decoded fields otherwise.
  always_comb begin
    ereg_stat_d  = D_stat;
    ereg_icode_d = D_icode;
    ereg_ifun_d  = D_ifun;
    ereg_valc_d  = D_valC;
    ereg_vala_d  = d_valA;
    ereg_valb_d  = d_valB;
    ereg_dste_d  = d_dstE;
    ereg_dstm_d  = d_dstM;
    ereg_srca_d  = d_srcA;
    ereg_srcb_d  = d_srcB;
    if (E_bubble) begin
      ereg_stat_d  = StatAok;
      ereg_icode_d = INop;
      ereg_ifun_d  = 4'h0;
      ereg_valc_d  = '0;
      ereg_vala_d  = '0;
      ereg_valb_d  = '0;
      ereg_dste_d  = RNONE;
      ereg_dstm_d  = RNONE;
      ereg_srca_d  = RNONE;
      ereg_srcb_d  = RNONE;
    end
  end

  // E register state; reset loads the nop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ereg_stat_q  <= StatAok;
      ereg_icode_q <= INop;
      ereg_ifun_q  <= 4'h0;
      ereg_valc_q  <= '0;
      ereg_vala_q  <= '0;
      ereg_valb_q  <= '0;
      ereg_dste_q  <= RNONE;
      ereg_dstm_q  <= RNONE;
      ereg_srca_q  <= RNONE;
      ereg_srcb_q  <= RNONE;
    end else begin
      ereg_stat_q  <= ereg_stat_d;
      ereg_icode_q <= ereg_icode_d;
      ereg_ifun_q  <= ereg_ifun_d;
      ereg_valc_q  <= ereg_valc_d;
      ereg_vala_q  <= ereg_vala_d;
      ereg_valb_q  <= ereg_valb_d;
      ereg_dste_q  <= ereg_dste_d;
      ereg_dstm_q  <= ereg_dstm_d;
      ereg_srca_q  <= ereg_srca_d;
      ereg_srcb_q  <= ereg_srcb_d;
    end
  end

  assign E_stat  = ereg_stat_q;
  assign E_icode = ereg_icode_q;
  assign E_ifun  = ereg_ifun_q;
  assign E_valC  = ereg_valc_q;
  assign E_valA  = ereg_vala_q;
  assign E_valB  = ereg_valb_q;
  assign E_dstE  = ereg_dste_q;
  assign E_dstM  = ereg_dstm_q;
  assign E_srcA  = ereg_srca_q;
  assign E_srcB  = ereg_srcb_q;

`ifdef DBG_REGFILE_EN
  assign dbg_data = rf_read(dbg_addr);
`endif

endmodule

// File: tb/tb_decode_e_stage.sv
// Directed table-driven bench for decode_e_stage, plus async-reset sequences.
module tb_decode_e_stage;

  logic        clk;
  logic        rst_n;
  logic [2:0]  D_stat;
  logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
  logic [63:0] D_valC, D_valP;
  logic        E_bubble;
  logic [3:0]  e_dstE, M_dstM, M_dstE, W_dstM, W_dstE;
  logic [63:0] e_valE, m_valM, M_valE, W_valM, W_valE;
  logic [3:0]  d_srcA, d_srcB;
  logic [2:0]  E_stat;
  logic [3:0]  E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
  logic [63:0] E_valC, E_valA, E_valB;
`ifdef DBG_REGFILE_EN
  logic [3:0]  dbg_addr;
  logic [63:0] dbg_data;
`endif

  int checks = 0;
  int errors = 0;

  decode_e_stage #(.WIDTH(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
    .D_valC(D_valC), .D_valP(D_valP), .E_bubble(E_bubble),
    .e_dstE(e_dstE), .e_valE(e_valE),
    .M_dstM(M_dstM), .M_dstE(M_dstE), .m_valM(m_valM), .M_valE(M_valE),
    .W_dstM(W_dstM), .W_dstE(W_dstE), .W_valM(W_valM), .W_valE(W_valE),
    .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
    .E_dstE(E_dstE), .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB)
`ifdef DBG_REGFILE_EN
    , .dbg_addr(dbg_addr), .dbg_data(dbg_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  stat;
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc, valp;
    logic        bubble;
    logic [3:0]  ed;  logic [63:0] ev;
    logic [3:0]  mdm; logic [63:0] mvm;
    logic [3:0]  mde; logic [63:0] mve;
    logic [3:0]  wdm; logic [63:0] wvm;
    logic [3:0]  wde; logic [63:0] wve;
    // expected
    logic [3:0]  x_dsrca, x_dsrcb;
    logic [2:0]  x_stat;
    logic [3:0]  x_icode, x_ifun;
    logic [63:0] x_valc, x_vala, x_valb;
    logic [3:0]  x_dste, x_dstm, x_srca, x_srcb;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic [3:0] icode, input logic [3:0] ra,
                              input logic [3:0] rb, input logic [63:0] valc,
                              input logic [63:0] valp);
    vec_t v;
    v.stat = 3'd1; v.icode = icode; v.ifun = 4'h0; v.ra = ra; v.rb = rb;
    v.valc = valc; v.valp = valp; v.bubble = 1'b0;
    v.ed = 4'hF; v.ev = 64'h0; v.mdm = 4'hF; v.mvm = 64'h0;
    v.mde = 4'hF; v.mve = 64'h0; v.wdm = 4'hF; v.wvm = 64'h0;
    v.wde = 4'hF; v.wve = 64'h0;
    v.x_dsrca = 4'hF; v.x_dsrcb = 4'hF;
    v.x_stat = 3'd1; v.x_icode = icode; v.x_ifun = 4'h0; v.x_valc = valc;
    v.x_vala = 64'h0; v.x_valb = 64'h0;
    v.x_dste = 4'hF; v.x_dstm = 4'hF; v.x_srca = 4'hF; v.x_srcb = 4'hF;
    return v;
  endfunction

  // Expected decode + operand values for a non-bubbled vector.
  function automatic vec_t ex(input vec_t vi, input logic [3:0] sa, input logic [3:0] sb,
                              input logic [3:0] de, input logic [3:0] dm,
                              input logic [63:0] va, input logic [63:0] vb);
    vec_t v;
    v = vi;
    v.x_dsrca = sa; v.x_dsrcb = sb; v.x_srca = sa; v.x_srcb = sb;
    v.x_dste = de; v.x_dstm = dm; v.x_vala = va; v.x_valb = vb;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %h expected %h", name, idx, got, exp);
    end
  endtask

  task automatic chk_nop(input string tag);
    chk({tag, " E_icode"}, -1, 64'(E_icode), 64'h1);
    chk({tag, " E_ifun"},  -1, 64'(E_ifun),  64'h0);
    chk({tag, " E_stat"},  -1, 64'(E_stat),  64'h1);
    chk({tag, " E_valC"},  -1, E_valC, 64'h0);
    chk({tag, " E_valA"},  -1, E_valA, 64'h0);
    chk({tag, " E_valB"},  -1, E_valB, 64'h0);
    chk({tag, " E_dstE"},  -1, 64'(E_dstE), 64'hF);
    chk({tag, " E_dstM"},  -1, 64'(E_dstM), 64'hF);
    chk({tag, " E_srcA"},  -1, 64'(E_srcA), 64'hF);
    chk({tag, " E_srcB"},  -1, 64'(E_srcB), 64'hF);
  endtask

  task automatic drive(input vec_t v);
    D_stat = v.stat; D_icode = v.icode; D_ifun = v.ifun; D_rA = v.ra; D_rB = v.rb;
    D_valC = v.valc; D_valP = v.valp; E_bubble = v.bubble;
    e_dstE = v.ed; e_valE = v.ev; M_dstM = v.mdm; m_valM = v.mvm;
    M_dstE = v.mde; M_valE = v.mve; W_dstM = v.wdm; W_valM = v.wvm;
    W_dstE = v.wde; W_valE = v.wve;
  endtask

  vec_t v;

  initial begin
    // v0 irmovq $0x10, %rdx
    v = mk(4'h3, 4'hF, 4'h2, 64'h10, 64'h0A);
    vecs[0] = ex(v, 4'hF, 4'hF, 4'h2, 4'hF, 64'h0, 64'h0);
    // v1 nop while W writes r3 = 0x55
    v = mk(4'h1, 4'hF, 4'hF, 64'h0, 64'h0); v.wde = 4'h3; v.wve = 64'h55;
    vecs[1] = v;
    // v2 OPq rA=3 rB=F reads regfile
    v = mk(4'h6, 4'h3, 4'hF, 64'h0, 64'h0);
    vecs[2] = ex(v, 4'h3, 4'hF, 4'hF, 4'hF, 64'h55, 64'h0);
    // v3 OPq r1,r1 with e/M/W all targeting r1: e wins
    v = mk(4'h6, 4'h1, 4'h1, 64'h0, 64'h0);
    v.ed = 4'h1; v.ev = 64'hA; v.mde = 4'h1; v.mve = 64'hB; v.wde = 4'h1; v.wve = 64'hC;
    vecs[3] = ex(v, 4'h1, 4'h1, 4'h1, 4'hF, 64'hA, 64'hA);
    // v4 same without e: M_valE wins
    v.ed = 4'hF;
    vecs[4] = ex(v, 4'h1, 4'h1, 4'h1, 4'hF, 64'hB, 64'hB);
    // v5 no forwarding: regfile r1 = 0xC
    v = mk(4'h6, 4'h1, 4'h1, 64'h0, 64'h0);
    vecs[5] = ex(v, 4'h1, 4'h1, 4'h1, 4'hF, 64'hC, 64'hC);
    // v6 call: valA = valP
    v = mk(4'h8, 4'hF, 4'hF, 64'h200, 64'h40);
    vecs[6] = ex(v, 4'hF, 4'h4, 4'h4, 4'hF, 64'h40, 64'h0);
    // v7 pushq r3 with M_dstE=rsp forward
    v = mk(4'hA, 4'h3, 4'hF, 64'h0, 64'h0); v.mde = 4'h4; v.mve = 64'h1F8;
    vecs[7] = ex(v, 4'h3, 4'h4, 4'h4, 4'hF, 64'h55, 64'h1F8);
    // v8 nop while W writes r5 from both ports: valM must win
    v = mk(4'h1, 4'hF, 4'hF, 64'h0, 64'h0);
    v.wde = 4'h5; v.wve = 64'h1; v.wdm = 4'h5; v.wvm = 64'h2;
    vecs[8] = v;
    // v9 OPq r5,r5 from regfile
    v = mk(4'h6, 4'h5, 4'h5, 64'h0, 64'h0);
    vecs[9] = ex(v, 4'h5, 4'h5, 4'h5, 4'hF, 64'h2, 64'h2);
    // v10 bubble with mrmovq in D: E gets nop, d_src still decoded
    v = mk(4'h5, 4'h6, 4'h3, 64'h8, 64'h0); v.bubble = 1'b1;
    v.x_dsrca = 4'hF; v.x_dsrcb = 4'h3; v.x_icode = 4'h1; v.x_valc = 64'h0;
    vecs[10] = v;
    // v11 same mrmovq unbubbled
    v = mk(4'h5, 4'h6, 4'h3, 64'h8, 64'h0);
    vecs[11] = ex(v, 4'hF, 4'h3, 4'hF, 4'h6, 64'h0, 64'h55);
    // v12 popq r7 with ADR status; M_dstM beats W_dstE; W writes rsp=0x33
    v = mk(4'hB, 4'h7, 4'hF, 64'h0, 64'h0); v.stat = 3'd2; v.x_stat = 3'd2;
    v.mdm = 4'h4; v.mvm = 64'h99; v.wde = 4'h4; v.wve = 64'h33;
    vecs[12] = ex(v, 4'h4, 4'h4, 4'h4, 4'h7, 64'h99, 64'h99);
    // v13 ret reads rsp from regfile
    v = mk(4'h9, 4'hF, 4'hF, 64'h0, 64'h0);
    vecs[13] = ex(v, 4'h4, 4'h4, 4'h4, 4'hF, 64'h33, 64'h33);
    // v14 rrmovq r4->r8, W_dstM beats W_dstE on forward and on write
    v = mk(4'h2, 4'h4, 4'h8, 64'h0, 64'h0); v.ifun = 4'h3; v.x_ifun = 4'h3;
    v.wdm = 4'h4; v.wvm = 64'h44; v.wde = 4'h4; v.wve = 64'h11;
    vecs[14] = ex(v, 4'h4, 4'hF, 4'h8, 4'hF, 64'h44, 64'h0);
    // v15 jXX: valA = valP even with a rA field set
    v = mk(4'h7, 4'h4, 4'hF, 64'h300, 64'h123); v.ifun = 4'h1; v.x_ifun = 4'h1;
    vecs[15] = ex(v, 4'hF, 4'hF, 4'hF, 4'hF, 64'h123, 64'h0);
    // v16 rmmovq r4 -> 8(r2)
    v = mk(4'h4, 4'h4, 4'h2, 64'h8, 64'h0);
    vecs[16] = ex(v, 4'h4, 4'h2, 4'hF, 4'hF, 64'h44, 64'h0);

    // Reset with a live instruction and write presented: reset must override.
    rst_n = 1'b0;
    v = mk(4'h6, 4'h1, 4'h1, 64'h0, 64'h0); v.wde = 4'h1; v.wve = 64'hDEAD;
    drive(v);
`ifdef DBG_REGFILE_EN
    dbg_addr = 4'h1;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk_nop("reset");
`ifdef DBG_REGFILE_EN
    chk("reset dbg r1", -1, dbg_data, 64'h0);
`endif
    rst_n = 1'b1;
    drive(vecs[0]);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      #1;
      chk("d_srcA", i, 64'(d_srcA), 64'(vecs[i].x_dsrca));
      chk("d_srcB", i, 64'(d_srcB), 64'(vecs[i].x_dsrcb));
      @(posedge clk);
      #1;
      chk("E_stat",  i, 64'(E_stat),  64'(vecs[i].x_stat));
      chk("E_icode", i, 64'(E_icode), 64'(vecs[i].x_icode));
      chk("E_ifun",  i, 64'(E_ifun),  64'(vecs[i].x_ifun));
      chk("E_valC",  i, E_valC, vecs[i].x_valc);
      chk("E_valA",  i, E_valA, vecs[i].x_vala);
      chk("E_valB",  i, E_valB, vecs[i].x_valb);
      chk("E_dstE",  i, 64'(E_dstE), 64'(vecs[i].x_dste));
      chk("E_dstM",  i, 64'(E_dstM), 64'(vecs[i].x_dstm));
      chk("E_srcA",  i, 64'(E_srcA), 64'(vecs[i].x_srca));
      chk("E_srcB",  i, 64'(E_srcB), 64'(vecs[i].x_srcb));
`ifdef DBG_REGFILE_EN
      if (i == 8) begin
        dbg_addr = 4'h5;
        #1 chk("dbg r5", i, dbg_data, 64'h2);
        dbg_addr = 4'hF;
        #1 chk("dbg rnone", i, dbg_data, 64'h0);
      end
`endif
    end

    // Mid-cycle asynchronous reset: E goes to nop without a clock edge.
    v = mk(4'h1, 4'hF, 4'hF, 64'h0, 64'h0);
    drive(v);
    #2;
    rst_n = 1'b0;
    #1;
    chk_nop("async reset");
`ifdef DBG_REGFILE_EN
    dbg_addr = 4'h4;
    #1 chk("async dbg r4", -1, dbg_data, 64'h0);
`endif
    #1;
    rst_n = 1'b1;
    // Registers previously written (r1, r3, r4, r5) must now read zero.
    v = mk(4'h6, 4'h4, 4'h3, 64'h0, 64'h0);
    drive(v);
    @(posedge clk);
    #1;
    chk("post-reset E_icode", -1, 64'(E_icode), 64'h6);
    chk("post-reset r4", -1, E_valA, 64'h0);
    chk("post-reset r3", -1, E_valB, 64'h0);
    v = mk(4'h6, 4'h1, 4'h5, 64'h0, 64'h0);
    drive(v);
    @(posedge clk);
    #1;
    chk("post-reset r1", -1, E_valA, 64'h0);
    chk("post-reset r5", -1, E_valB, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
